// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner
//
// Drives and scans the 4x4 CHIP-8 hex keypad matrix, debounces every key
// and reports the debounced key vector plus the index of the most recently
// pressed key. The core discards a stale key by raising
// clear_newest_key_down, then waits for newest_key_down < 16.
//
// Ports:
//   clk                    system clock (shared with the core)
//   rst_n                  synchronous active-low reset
//   col_out[3:0]           column drive, active-low, one column low at a time
//   row_in[3:0]            row sense, active-low, asynchronous to clk
//   input_keys[15:0]       debounced key state, bit k = hex key k pressed
//   newest_key_down[4:0]   index of the newest debounced press, 16 = none
//   clear_newest_key_down  rising edge discards the held newest key
//
// Parameters:
//   SCAN_DIV        clk cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive differing samples needed to flip a key (>= 1)

module chip8_keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  col_out,
   input  logic [3:0]  row_in,
   output logic [15:0] input_keys,
   output logic [4:0]  newest_key_down,
   input  logic        clear_newest_key_down
);

   localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);

   logic [DWELL_W-1:0]        dwell;
   logic [1:0]                col;
   logic [3:0]                row_meta;
   logic [3:0]                row_sync;
   logic [3:0]                pressed_rows;
   logic                      sample;
   logic [15:0]               stable;
   logic [15:0]               stable_nxt;
   logic [15:0][CNT_W-1:0]    cnt;
   logic [15:0][CNT_W-1:0]    cnt_nxt;
   logic [15:0]               press;
   logic                      press_any;
   logic [3:0]                press_idx;
   logic [3:0]                key_sel;
   logic                      clear_d;
   logic [4:0]                newest;

   // Matrix position to hex key, following the printed keypad layout.
   function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
      key_at = 4'h0;
      case ({r, c})
         4'b00_00: key_at = 4'h1;
         4'b00_01: key_at = 4'h2;
         4'b00_10: key_at = 4'h3;
         4'b00_11: key_at = 4'hC;
         4'b01_00: key_at = 4'h4;
         4'b01_01: key_at = 4'h5;
         4'b01_10: key_at = 4'h6;
         4'b01_11: key_at = 4'hD;
         4'b10_00: key_at = 4'h7;
         4'b10_01: key_at = 4'h8;
         4'b10_10: key_at = 4'h9;
         4'b10_11: key_at = 4'hE;
         4'b11_00: key_at = 4'hA;
         4'b11_01: key_at = 4'h0;
         4'b11_10: key_at = 4'hB;
         4'b11_11: key_at = 4'hF;
         default:  key_at = 4'h0;
      endcase
   endfunction

   // Rows are only looked at on the last dwell cycle of a column, so the
   // synchroniser output by then reflects rows that settled under this column.
   assign sample       = (dwell == DWELL_LAST);
   assign pressed_rows = ~row_sync;
   assign col_out      = ~(4'b0001 << col);
   assign input_keys   = stable;
   assign newest_key_down = newest;

   // Row synchroniser and clear edge-detect history.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_meta <= '0;
         row_sync <= '0;
         clear_d  <= 1'b0;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
         clear_d  <= clear_newest_key_down;
      end
   end

   // Column dwell counter; the column advances on the cycle after its sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell <= '0;
         col   <= 2'd0;
      end else if (sample) begin
         dwell <= '0;
         col   <= col + 2'd1;
      end else begin
         dwell <= dwell + DWELL_W'(1);
      end
   end

   // Debounce of the four keys in the current column. A counter only runs
   // while the sample disagrees with the stable state; any agreeing sample
   // restarts it, so a flip needs DEBOUNCE_SCANS consecutive disagreements.
   always_comb begin
      stable_nxt = stable;
      cnt_nxt    = cnt;
      press      = '0;
      key_sel    = 4'h0;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            key_sel = key_at(2'(r), col);
            if (pressed_rows[r] == stable[key_sel]) begin
               cnt_nxt[key_sel] = '0;
            end else if (cnt[key_sel] == CNT_LAST) begin
               stable_nxt[key_sel] = pressed_rows[r];
               cnt_nxt[key_sel]    = '0;
               press[key_sel]      = pressed_rows[r];
            end else begin
               cnt_nxt[key_sel] = cnt[key_sel] + CNT_W'(1);
            end
         end
      end
   end

   // Simultaneous presses resolve to the lowest hex index.
   always_comb begin
      press_any = 1'b0;
      press_idx = 4'h0;
      for (int i = 15; i >= 0; i--) begin
         if (press[i]) begin
            press_any = 1'b1;
            press_idx = 4'(i);
         end
      end
   end

   // Debounced state, counters and the newest-key register. A press event
   // takes priority over a clear edge arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable <= '0;
         cnt    <= '0;
         newest <= 5'd16;
      end else begin
         stable <= stable_nxt;
         cnt    <= cnt_nxt;
         if (press_any) begin
            newest <= {1'b0, press_idx};
         end else if (clear_newest_key_down && !clear_d) begin
            newest <= 5'd16;
         end
      end
   end

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// tb_chip8_keypad_scanner
//
// Self-checking bench for chip8_keypad_scanner. A simulated keypad turns a
// bitmask of physically held keys into row_in from the driven column. A
// behavioural model, built from scan timing arithmetic and per-key runs of
// disagreeing samples, predicts every output each cycle; a vector table and
// hand-written sequences add fixed expectations for the key scenarios.

module tb_chip8_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  col_out;
   logic [3:0]  row_in;
   logic [15:0] input_keys;
   logic [4:0]  newest_key_down;
   logic        clear;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] phys;
   logic [15:0] seenKeys;
   int          keyAt [4][4];

   // Reference model state
   int          mT;
   logic [15:0] mStable;
   int          mRun [16];
   logic [4:0]  mNewest;
   logic        mClearPrev;
   logic [15:0] mHist [3];

   typedef struct {
      string       name;
      logic [15:0] keys;
      logic        clr;
      int          cycles;
      logic [15:0] expKeys;
      logic [4:0]  expNewest;
   } vec_t;

   vec_t vecs [11];
   logic [3:0] colSeq [17];

   chip8_keypad_scanner #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .col_out               (col_out),
      .row_in                (row_in),
      .input_keys            (input_keys),
      .newest_key_down       (newest_key_down),
      .clear_newest_key_down (clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Keypad model: a row reads low when a held key sits on a driven column.
   function automatic logic [3:0] rowsFor(input logic [15:0] keys, input logic [3:0] cols);
      logic [3:0] rows;
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!cols[c] && keys[keyAt[r][c]]) rows[r] = 1'b0;
      return rows;
   endfunction

   task automatic modelReset();
      mT = 0;
      mStable = '0;
      for (int k = 0; k < 16; k++) mRun[k] = 0;
      mNewest = 5'd16;
      mClearPrev = 1'b0;
      for (int h = 0; h < 3; h++) mHist[h] = '0;
   endtask

   // One clock edge: a column sample sees the keypad as it was two edges ago.
   task automatic modelEdge();
      int c;
      int k;
      int bestKey;
      logic s;
      mHist[2] = mHist[1];
      mHist[1] = mHist[0];
      mHist[0] = phys;
      bestKey = 16;
      if (mT % SD == SD - 1) begin
         c = (mT / SD) % 4;
         for (int r = 0; r < 4; r++) begin
            k = keyAt[r][c];
            s = mHist[2][k];
            if (s == mStable[k]) begin
               mRun[k] = 0;
            end else begin
               mRun[k]++;
               if (mRun[k] == DB) begin
                  mStable[k] = s;
                  mRun[k] = 0;
                  if (s && k < bestKey) bestKey = k;
               end
            end
         end
      end
      if (bestKey < 16) mNewest = 5'(bestKey);
      else if (clear && !mClearPrev) mNewest = 5'd16;
      mClearPrev = clear;
      mT++;
   endtask

   task automatic checkOutput();
      logic [3:0] expCol;
      expCol = ~(4'b0001 << ((mT / SD) % 4));
      checkVal("model col_out", col_out, expCol);
      checkVal("model input_keys", input_keys, mStable);
      checkVal("model newest_key_down", newest_key_down, mNewest);
   endtask

   // Called at a negedge: drive inputs, take one edge, check at next negedge.
   task automatic applyStimulus(input logic [15:0] keys, input logic clr, input logic rst);
      phys   = keys;
      clear  = clr;
      rst_n  = ~rst;
      row_in = rowsFor(phys, col_out);
      @(posedge clk);
      if (rst) modelReset();
      else     modelEdge();
      @(negedge clk);
      checkOutput();
      seenKeys |= input_keys;
   endtask

   task automatic setVec(input int i, input string n, input logic [15:0] k, input logic c,
                         input int cyc, input logic [15:0] ek, input logic [4:0] en);
      vecs[i].name = n;
      vecs[i].keys = k;
      vecs[i].clr = c;
      vecs[i].cycles = cyc;
      vecs[i].expKeys = ek;
      vecs[i].expNewest = en;
   endtask

   initial begin
      logic [15:0] rk;
      logic        rc;
      logic        rr;

      keyAt = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};
      rst_n = 1'b0;
      clear = 1'b0;
      phys = '0;
      row_in = 4'hF;
      seenKeys = '0;
      modelReset();

      setVec(0,  "idle",              16'h0000, 1'b0, 20, 16'h0000, 5'd16);
      setVec(1,  "press 5",           16'h0020, 1'b0, 64, 16'h0020, 5'd5);
      setVec(2,  "release 5",         16'h0000, 1'b0, 64, 16'h0000, 5'd5);
      setVec(3,  "clear edge",        16'h0000, 1'b1, 4,  16'h0000, 5'd16);
      setVec(4,  "press F clear hi",  16'h8000, 1'b1, 64, 16'h8000, 5'd15);
      setVec(5,  "hold F clear hi",   16'h8000, 1'b1, 16, 16'h8000, 5'd15);
      setVec(6,  "release F",         16'h0000, 1'b0, 64, 16'h0000, 5'd15);
      setVec(7,  "press 1 and 4",     16'h0012, 1'b0, 64, 16'h0012, 5'd1);
      setVec(8,  "add 6",             16'h0052, 1'b0, 64, 16'h0052, 5'd6);
      setVec(9,  "release all",       16'h0000, 1'b0, 64, 16'h0000, 5'd6);
      setVec(10, "clear again",       16'h0000, 1'b1, 2,  16'h0000, 5'd16);

      for (int i = 0; i < 17; i++) colSeq[i] = 4'b1110;
      for (int i = 4; i < 8; i++)  colSeq[i] = 4'b1101;
      for (int i = 8; i < 12; i++) colSeq[i] = 4'b1011;
      for (int i = 12; i < 16; i++) colSeq[i] = 4'b0111;

      $display("[TB] start");
      @(negedge clk);
      applyStimulus(16'h0000, 1'b0, 1'b1);
      applyStimulus(16'h0000, 1'b0, 1'b1);
      checkVal("reset col_out", col_out, 4'b1110);
      checkVal("reset input_keys", input_keys, 16'h0000);
      checkVal("reset newest", newest_key_down, 5'd16);

      // Free-running scan order after reset
      for (int i = 1; i < 17; i++) begin
         applyStimulus(16'h0000, 1'b0, 1'b0);
         checkVal($sformatf("scan col cycle %0d", i), col_out, colSeq[i]);
      end

      // Vector table
      for (int v = 0; v < 11; v++) begin
         for (int n = 0; n < vecs[v].cycles; n++)
            applyStimulus(vecs[v].keys, vecs[v].clr, 1'b0);
         checkVal({vecs[v].name, " keys"}, input_keys, vecs[v].expKeys);
         checkVal({vecs[v].name, " newest"}, newest_key_down, vecs[v].expNewest);
      end

      // Key A held for exactly two column-0 samples must never register
      applyStimulus(16'h0000, 1'b0, 1'b1);
      seenKeys = '0;
      for (int i = 0; i < 20; i++) applyStimulus(16'h0400, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) applyStimulus(16'h0000, 1'b0, 1'b0);
      checkVal("keyA glitch keys seen", seenKeys, 16'h0000);
      checkVal("keyA glitch newest", newest_key_down, 5'd16);

      // Reset with key 9 two samples into its debounce
      applyStimulus(16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++) applyStimulus(16'h0200, 1'b0, 1'b0);
      checkVal("key9 pre-reset keys", input_keys, 16'h0000);
      applyStimulus(16'h0200, 1'b0, 1'b1);
      checkVal("key9 reset col_out", col_out, 4'b1110);
      checkVal("key9 reset keys", input_keys, 16'h0000);
      checkVal("key9 reset newest", newest_key_down, 5'd16);
      for (int i = 0; i < 40; i++) applyStimulus(16'h0200, 1'b0, 1'b0);
      checkVal("key9 two samples keys", input_keys, 16'h0000);
      checkVal("key9 two samples newest", newest_key_down, 5'd16);
      for (int i = 0; i < 10; i++) applyStimulus(16'h0200, 1'b0, 1'b0);
      checkVal("key9 third sample keys", input_keys, 16'h0200);
      checkVal("key9 third sample newest", newest_key_down, 5'd9);

      // Random keypad activity, clear toggling and occasional resets
      rk = '0;
      rc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         int b;
         if ($urandom_range(0, 99) < 6) begin
            b = int'($urandom_range(0, 15));
            rk[b] = ~rk[b];
         end
         if ($countones(rk) > 4) rk = '0;
         if ($urandom_range(0, 15) == 0) rc = ~rc;
         rr = ($urandom_range(0, 999) == 0);
         applyStimulus(rk, rc, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/chip8_keypad_scanner.md
Name: chip8_keypad_scanner

Overview:
Drives and scans the 4x4 CHIP-8 hex keypad matrix and debounces each key. Publishes the 16-bit key-state vector and a "newest key down" index consumed by the chip8 core. Implements the scanner side of the core's key handshake: the core raises clear_newest_key_down to discard any stale key, then waits for newest_key_down < 16. Sits between the board keypad pins and the chip8 core.

Parameters:
SCAN_DIV, 4, clk cycles each column is driven; must be >= 4.
DEBOUNCE_SCANS, 3, consecutive differing samples of a key needed to change its debounced state; must be >= 1.

Ports:
clk  input  1  system clock, the same clock as the core's instruction clock.
rst_n  input  1  synchronous active-low reset.
col_out  output  4  matrix column drive, active-low; exactly one bit is low at a time.
row_in  input  4  matrix row sense, active-low, pulled up externally, asynchronous.
input_keys  output  16  debounced key state; bit k = 1 means hex key k is pressed.
newest_key_down  output  5  hex index 0-15 of the most recent debounced press; 5'd16 means none.
clear_newest_key_down  input  1  from the core; a rising edge discards the held newest key.

Behaviour:
- Reset (rst_n sampled low at a posedge):
  - col_out=4'b1110.
  - input_keys=0.
  - newest_key_down=5'd16.
  - Dwell counter, column index, all debounce counters, row synchronisers and the clear edge-detector register are all cleared.
  - Reset takes effect mid-scan or mid-debounce with no residue.
- Row sync: row_in passes through a 2-flop synchroniser; raw pressed = ~row_sync.
- Scan:
  - Dwell counter runs 0..SCAN_DIV-1 on column c (c = 0..3), with col_out = ~(1<<c).
  - Rows are sampled when dwell == SCAN_DIV-1.
  - On the next cycle c advances, wrapping 3 -> 0, and dwell returns to 0.
  - Full scan period is 4*SCAN_DIV cycles.
- Key map: row r, column c gives hex key:
  - row0 = 1,2,3,C
  - row1 = 4,5,6,D
  - row2 = 7,8,9,E
  - row3 = A,0,B,F
- Debounce (per key, evaluated only on its own column's sample cycle):
  - If sample == stable: counter <= 0.
  - Else if counter == DEBOUNCE_SCANS-1: stable <= sample and counter <= 0.
  - Else: counter increments.
  - input_keys is the registered stable vector and updates the cycle after the sample cycle.
- Press event: a stable 0->1 transition of key k.
  - Release events never affect newest_key_down.
  - Several press events in one sample cycle (same column) -> the lowest hex index wins.
- Newest key:
  - clear_d <= clear_newest_key_down every cycle.
  - Rising edge (clear high, clear_d low) with no press event that cycle -> newest_key_down <= 16.
  - A press event, in any cycle, loads its index; a press event beats a simultaneous clear edge.
  - Otherwise newest_key_down holds, including while clear stays high or low.
- Latency: a press stable from a column sample appears on input_keys/newest_key_down 1 cycle after the DEBOUNCE_SCANS-th consecutive pressed sample of that key.
- Row sampling happens only on a column's last dwell cycle, giving 2 or more cycles of settle after column switch and synchroniser delay.

Test Plan:
- Reset then free-run, SCAN_DIV=4 -> col_out 1110 for cycles 0-3, then 1101, 1011, 0111, back to 1110 at cycle 16; input_keys=0; newest_key_down=16 throughout.
- Hold row1 low while column 1 is driven (key 5), DEBOUNCE_SCANS=3 -> input_keys=16'h0020 and newest=5 one cycle after the 3rd column-1 sample; release -> input_keys=0 after 3 samples, newest stays 5.
- Key A (row3/col0) pressed for only 2 column-0 samples, then released -> input_keys never changes, newest stays 16.
- newest=5, raise clear -> newest=16 next cycle; hold clear high and press F (row3/col3) -> newest=15 after debounce; clear still high -> newest stays 15.
- Keys 1 and 4 (col0, rows 0 and 1) pressed together -> input_keys=16'h0012 and newest=1; then press 6 (col2) -> newest=6.
- Assert rst_n low one cycle with key 9 mid-debounce (counter at 2) -> all outputs return to reset values; key 9 must again accumulate 3 samples before appearing.
